// File: rtl/sym_mod_sched_pkg.sv
// Shared definitions for the per-symbol modulation scheduler: MOD codes,
// bits-per-word lookup and FSM state encoding.
package sym_mod_sched_pkg;

  localparam logic [1:0] MOD_Q64  = 2'b11;
  localparam logic [1:0] MOD_Q16  = 2'b10;
  localparam logic [1:0] MOD_QPSK = 2'b00;
  localparam logic [1:0] MOD_BPSK = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2,
    ST_END  = 2'd3
  } state_e;

  function automatic logic [2:0] k_of_mod(input logic [1:0] m);
    logic [2:0] k;
    case (m)
      MOD_Q64:  k = 3'd6;
      MOD_Q16:  k = 3'd4;
      MOD_QPSK: k = 3'd2;
      default:  k = 3'd1;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sym_bit_packer.sv
// Bit buffer for the scheduler: appends bytes above the held bits and
// shifts out k-bit mapper words LSB first.
module sym_bit_packer #(
  parameter int BUF_W = 14
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       acc_i,
  input  logic [7:0] byte_i,
  input  logic       emit_i,
  input  logic [2:0] k_i,
  input  logic       clr_i,
  output logic [5:0] word_o,
  output logic       enough_o,
  output logic       room_o
);

  localparam int CW = $clog2(BUF_W + 1);

  logic [BUF_W-1:0] buf_q, buf_d, app;
  logic [CW-1:0]    cnt_q, cnt_d, take;

  // Bits above cnt are always zero, so a short word in PAD reads zeros.
  assign word_o   = buf_q[5:0] & ((6'd1 << k_i) - 6'd1);
  assign enough_o = cnt_q >= CW'(k_i);
  assign room_o   = ({1'b0, cnt_q} + (CW+1)'(8)) <= (CW+1)'(BUF_W);

  always_comb begin
    app   = buf_q;
    take  = (CW'(k_i) < cnt_q) ? CW'(k_i) : cnt_q;
    if (acc_i) app = buf_q | (BUF_W'(byte_i) << cnt_q);
    buf_d = emit_i ? (app >> k_i) : app;
    cnt_d = cnt_q + (acc_i ? CW'(8) : CW'(0)) - (emit_i ? take : CW'(0));
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sym_mod_sched.sv
// Per-OFDM-symbol modulation scheduler and bit packer. Optional statistics
// outputs (SYM_CNT_O, PAD_CNT_O) are built when SYM_SCHED_STAT_EN is defined.
module sym_mod_sched
  import sym_mod_sched_pkg::*;
#(
  parameter int NSC   = 48,
  parameter int SCW   = 6,
  parameter int BUF_W = 14
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic [7:0]     DAT_I,
  input  logic           CYC_I,
  input  logic           STB_I,
  input  logic           WE_I,
  output logic           ACK_O,
  output logic [5:0]     DAT_O,
  output logic           CYC_O,
  output logic           STB_O,
  output logic           WE_O,
  input  logic           ACK_I,
  output logic [1:0]     MOD_O,
  input  logic [1:0]     MOD_CFG_I,
  output logic [1:0]     DBG_STATE_O
`ifdef SYM_SCHED_STAT_EN
  ,
  output logic [15:0]    SYM_CNT_O,
  output logic [SCW-1:0] PAD_CNT_O
`endif
);

  // Handshakes: a byte moves on a clock edge where CYC_I&STB_I&WE_I&ACK_O;
  // a word moves on an edge where STB_O&ACK_I, and STB_O/DAT_O/MOD_O hold
  // until then.
  state_e         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [1:0]     mod_q, mod_d;
  logic [5:0]     dat_q, dat_d;
  logic           stb_q, stb_d, cyc_q, cyc_d;
  logic           halt, emit, acc, pk_clr, sym_start, sc_last;
  logic           enough, room;
  logic [2:0]     k_eff;
  logic [5:0]     word;

  assign halt      = stb_q & ~ACK_I;
  assign sym_start = (sc_q == '0);
  assign sc_last   = (sc_q == SCW'(NSC - 1));
  // The first word of a symbol is sliced with the modulation about to latch.
  assign k_eff     = sym_start ? k_of_mod(MOD_CFG_I) : k_of_mod(mod_q);
  assign acc       = CYC_I & STB_I & WE_I & (state_q == ST_RUN) & room;

  sym_bit_packer #(.BUF_W(BUF_W)) u_packer (
    .clk_i    (CLK_I),
    .rst_ni   (RST_I),
    .acc_i    (acc),
    .byte_i   (DAT_I),
    .emit_i   (emit),
    .k_i      (k_eff),
    .clr_i    (pk_clr),
    .word_o   (word),
    .enough_o (enough),
    .room_o   (room)
  );

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    mod_d   = mod_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    stb_d   = halt;
    emit    = 1'b0;
    pk_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CYC_I) begin
          state_d = ST_RUN;
          cyc_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!halt && enough) begin
          emit = 1'b1;
        end else if (!CYC_I && !enough) begin
          state_d = sym_start ? ST_END : ST_PAD;
        end
      end
      ST_PAD: begin
        if (!halt) begin
          emit = 1'b1;
          if (sc_last) state_d = ST_END;
        end
      end
      ST_END: begin
        if (!stb_q || ACK_I) begin
          cyc_d   = 1'b0;
          pk_clr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (emit) begin
      dat_d = word;
      stb_d = 1'b1;
      if (sym_start) mod_d = MOD_CFG_I;
      sc_d  = sc_last ? '0 : sc_q + SCW'(1);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      mod_q   <= MOD_QPSK;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      mod_q   <= mod_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ACK_O       = acc;
  assign DAT_O       = dat_q;
  assign CYC_O       = cyc_q;
  assign STB_O       = stb_q;
  assign WE_O        = stb_q;
  assign MOD_O       = mod_q;
  assign DBG_STATE_O = state_q;

`ifdef SYM_SCHED_STAT_EN
  logic [15:0]    sym_cnt_q;
  logic [SCW-1:0] pad_cnt_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sym_cnt_q <= '0;
      pad_cnt_q <= '0;
    end else if (state_q == ST_IDLE && CYC_I) begin
      sym_cnt_q <= '0;
      pad_cnt_q <= '0;
    end else if (emit) begin
      if (sc_last) sym_cnt_q <= sym_cnt_q + 16'd1;
      if (state_q == ST_PAD) pad_cnt_q <= pad_cnt_q + SCW'(1);
    end
  end

  assign SYM_CNT_O = sym_cnt_q;
  assign PAD_CNT_O = pad_cnt_q;
`endif

endmodule

// File: tb/tb_sym_mod_sched.sv
// Directed bench for sym_mod_sched: expected {MOD,DAT} words are queued per
// frame and a monitor pops them on every STB_O&ACK_I handshake.
module tb_sym_mod_sched;
  import sym_mod_sched_pkg::*;

  localparam int NSC = 48;
  localparam int SCW = 6;

  logic           CLK_I = 1'b0;
  logic           RST_I = 1'b0;
  logic [7:0]     DAT_I = '0;
  logic           CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0, ACK_I = 1'b1;
  logic [1:0]     MOD_CFG_I = 2'b00;
  logic           ACK_O, CYC_O, STB_O, WE_O;
  logic [5:0]     DAT_O;
  logic [1:0]     MOD_O, DBG_STATE_O;
`ifdef SYM_SCHED_STAT_EN
  logic [15:0]    SYM_CNT_O;
  logic [SCW-1:0] PAD_CNT_O;
`endif

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  always #5 CLK_I = ~CLK_I;

  sym_mod_sched #(.NSC(NSC), .SCW(SCW), .BUF_W(14)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I), .MOD_O(MOD_O), .MOD_CFG_I(MOD_CFG_I),
    .DBG_STATE_O(DBG_STATE_O)
`ifdef SYM_SCHED_STAT_EN
    , .SYM_CNT_O(SYM_CNT_O), .PAD_CNT_O(PAD_CNT_O)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: sample well after the falling edge, before the next rising edge.
  initial begin
    forever begin
      @(negedge CLK_I);
      #2;
      if (RST_I && STB_O && ACK_I) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_extra actual=%0h required=none", {MOD_O, DAT_O});
        end else begin
          check("word", 32'({MOD_O, DAT_O}), 32'(exp_q.pop_front()));
        end
        check("we_eq_stb", 32'(WE_O), 32'd1);
      end
    end
  end

  task automatic push_words(input logic [1:0] m, input int reps, input logic [5:0] w0,
                            input logic [5:0] w1, input logic [5:0] w2, input logic [5:0] w3);
    for (int i = 0; i < reps; i++) begin
      exp_q.push_back({m, w0});
      exp_q.push_back({m, w1});
      exp_q.push_back({m, w2});
      exp_q.push_back({m, w3});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    DAT_I = b;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    do begin
      @(negedge CLK_I);
      n++;
    end while (!ACK_O && n < 200);
    if (!ACK_O) begin
      checks++;
      errors++;
      $display("FAIL byte_ack_timeout actual=0 required=1 byte=%0h", b);
    end
    @(posedge CLK_I);
    #1;
  endtask

  task automatic wait_frame_end(input string name);
    int n = 0;
    while (CYC_O && n < 3000) begin
      @(negedge CLK_I);
      n++;
    end
    check({name, "_cyc_drop"}, 32'(CYC_O), 32'd0);
    repeat (2) @(negedge CLK_I);
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_state_idle"}, 32'(DBG_STATE_O), 32'(ST_IDLE));
  endtask

  task automatic run_frame(input bit wait_end, input string name);
    @(posedge CLK_I);
    #1;
    CYC_I = 1'b1;
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i]);
    STB_I = 1'b0;
    WE_I  = 1'b0;
    CYC_I = 1'b0;
    if (wait_end) wait_frame_end(name);
  endtask

  task automatic wait_rx(input int target, input string name);
    int n = 0;
    while (rx_cnt < target && n < 3000) begin
      @(negedge CLK_I);
      n++;
    end
    check({name, "_reached"}, 32'(rx_cnt >= target), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    int base;
    logic [5:0] hd;
    logic [1:0] hm;

    // Reset state
    repeat (3) @(negedge CLK_I);
    check("rst_dat", 32'(DAT_O), 32'd0);
    check("rst_stb", 32'(STB_O), 32'd0);
    check("rst_cyc", 32'(CYC_O), 32'd0);
    check("rst_mod", 32'(MOD_O), 32'd0);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_state", 32'(DBG_STATE_O), 32'(ST_IDLE));
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // QPSK, 12 x 0x1B: 3,2,1,0 repeating, no pad
    MOD_CFG_I = MOD_QPSK;
    push_words(MOD_QPSK, 12, 6'd3, 6'd2, 6'd1, 6'd0);
    tx_q = {};
    for (int i = 0; i < 12; i++) tx_q.push_back(8'h1B);
    run_frame(1'b1, "qpsk");
`ifdef SYM_SCHED_STAT_EN
    check("qpsk_sym_cnt", 32'(SYM_CNT_O), 32'd1);
    check("qpsk_pad_cnt", 32'(PAD_CNT_O), 32'd0);
`endif

    // 64QAM, FF 00 AA: 3F 03 20 2A then 44 zero pad words
    MOD_CFG_I = MOD_Q64;
    push_words(MOD_Q64, 1, 6'h3F, 6'h03, 6'h20, 6'h2A);
    push_words(MOD_Q64, 11, 6'h00, 6'h00, 6'h00, 6'h00);
    tx_q = '{8'hFF, 8'h00, 8'hAA};
    run_frame(1'b1, "q64_pad");
`ifdef SYM_SCHED_STAT_EN
    check("q64_sym_cnt", 32'(SYM_CNT_O), 32'd1);
    check("q64_pad_cnt", 32'(PAD_CNT_O), 32'd44);
`endif

    // MOD_CFG_I changes mid-symbol: applies only from word 49
    MOD_CFG_I = MOD_QPSK;
    push_words(MOD_QPSK, 12, 6'd3, 6'd2, 6'd1, 6'd0);
    push_words(MOD_Q64, 12, 6'h3F, 6'h03, 6'h20, 6'h2A);
    tx_q = {};
    for (int i = 0; i < 12; i++) tx_q.push_back(8'h1B);
    for (int i = 0; i < 12; i++) begin
      tx_q.push_back(8'hFF);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'hAA);
    end
    base = rx_cnt;
    fork
      run_frame(1'b1, "mod_switch");
      begin
        wait_rx(base + 10, "cfg_word10");
        MOD_CFG_I = MOD_Q64;
      end
    join
`ifdef SYM_SCHED_STAT_EN
    check("switch_sym_cnt", 32'(SYM_CNT_O), 32'd2);
`endif

    // ACK_I low for 5 cycles mid-symbol
    MOD_CFG_I = MOD_QPSK;
    push_words(MOD_QPSK, 6, 6'd3, 6'd2, 6'd1, 6'd0);
    exp_q = {};
    for (int i = 0; i < 6; i++) begin
      push_words(MOD_QPSK, 1, 6'd3, 6'd2, 6'd1, 6'd0);
      push_words(MOD_QPSK, 1, 6'd0, 6'd1, 6'd2, 6'd3);
    end
    tx_q = {};
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'h1B);
      tx_q.push_back(8'hE4);
    end
    base = rx_cnt;
    fork
      run_frame(1'b1, "stall");
      begin
        int n = 0;
        do begin
          @(negedge CLK_I);
          n++;
        end while (!(STB_O && rx_cnt >= base + 8) && n < 2000);
        check("stall_start", 32'(STB_O), 32'd1);
        ACK_I = 1'b0;
        hd = DAT_O;
        hm = MOD_O;
        repeat (5) begin
          @(negedge CLK_I);
          check("halt_dat", 32'(DAT_O), 32'(hd));
          check("halt_mod", 32'(MOD_O), 32'(hm));
          check("halt_stb", 32'(STB_O), 32'd1);
        end
        check("halt_ack_o", 32'(ACK_O), 32'd0);
        ACK_I = 1'b1;
      end
    join

    // BPSK, 6 bytes: 48 single-bit words LSB first
    MOD_CFG_I = MOD_BPSK;
    tx_q = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = tx_q[i];
      for (int j = 0; j < 8; j++) exp_q.push_back({MOD_BPSK, 5'd0, b[j]});
    end
    run_frame(1'b1, "bpsk");

    // Reset during PAD, then a clean QPSK frame
    MOD_CFG_I = MOD_Q64;
    push_words(MOD_Q64, 1, 6'h3F, 6'h03, 6'h20, 6'h2A);
    push_words(MOD_Q64, 11, 6'h00, 6'h00, 6'h00, 6'h00);
    tx_q = '{8'hFF, 8'h00, 8'hAA};
    base = rx_cnt;
    run_frame(1'b0, "rst_pad");
    wait_rx(base + 10, "rst_pad_words");
    @(negedge CLK_I);
    check("pre_rst_state", 32'(DBG_STATE_O), 32'(ST_PAD));
    RST_I = 1'b0;
    #1;
    check("midrst_cyc", 32'(CYC_O), 32'd0);
    check("midrst_stb", 32'(STB_O), 32'd0);
    check("midrst_we", 32'(WE_O), 32'd0);
    check("midrst_mod", 32'(MOD_O), 32'd0);
    check("midrst_dat", 32'(DAT_O), 32'd0);
    check("midrst_state", 32'(DBG_STATE_O), 32'(ST_IDLE));
    exp_q.delete();
    @(negedge CLK_I);
    RST_I = 1'b1;
    MOD_CFG_I = MOD_QPSK;
    push_words(MOD_QPSK, 12, 6'd3, 6'd2, 6'd1, 6'd0);
    tx_q = {};
    for (int i = 0; i < 12; i++) tx_q.push_back(8'h1B);
    run_frame(1'b1, "after_rst");
`ifdef SYM_SCHED_STAT_EN
    check("after_rst_pad_cnt", 32'(PAD_CNT_O), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
